// File: rtl/raster_scan_driver.sv
// VGA raster scan front end for a combinational triangle rasterizer: timing, pixel
// coordinates, vertex registers and registered RGB222 output aligned with the syncs.
// Define VERTEX_DOUBLE_BUFFER_EN to build shadow vertices committed at vertical blanking.
module raster_scan_driver #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned H_TOTAL   = 800,
    parameter int unsigned V_TOTAL   = 525
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [9:0] wr_data,
    input  logic       wr_commit,
    output logic       commit_pending,
    input  logic [5:0] fg_color,
    input  logic [5:0] bg_color,
    output logic [9:0] pixel_col,
    output logic [8:0] pixel_row,
    output logic [9:0] v0_x,
    output logic [9:0] v1_x,
    output logic [9:0] v2_x,
    output logic [8:0] v0_y,
    output logic [8:0] v1_y,
    output logic [8:0] v2_y,
    input  logic       rasterize,
    output logic       hsync,
    output logic       vsync,
    output logic [5:0] rgb,
    output logic       frame_start
);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + 16);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + 16 + 96 - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + 10);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + 10 + 2 - 1);

    typedef struct packed {
        logic [9:0] v0_x;
        logic [8:0] v0_y;
        logic [9:0] v1_x;
        logic [8:0] v1_y;
        logic [9:0] v2_x;
        logic [8:0] v2_y;
    } vert_t;

    function automatic vert_t write_vertex(vert_t cur, logic [2:0] addr, logic [9:0] data);
        vert_t nxt;
        nxt = cur;
        case (addr)
            3'd0:    nxt.v0_x = data;
            3'd1:    nxt.v0_y = data[8:0];
            3'd2:    nxt.v1_x = data;
            3'd3:    nxt.v1_y = data[8:0];
            3'd4:    nxt.v2_x = data;
            3'd5:    nxt.v2_y = data[8:0];
            default: ;
        endcase
        return nxt;
    endfunction

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic [5:0] rgb_q, rgb_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       frame_start_q, frame_start_d;
    logic       display_on;
    vert_t      act_q, act_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end

        display_on = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        pixel_col  = (h_cnt_q < H_VIS) ? h_cnt_q : '0;
        pixel_row  = (v_cnt_q < V_VIS) ? v_cnt_q[8:0] : '0;

        rgb_d = '0;
        if (display_on) begin
            rgb_d = rasterize ? fg_color : bg_color;
        end
        hsync_d       = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
        vsync_d       = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
        frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

`ifdef VERTEX_DOUBLE_BUFFER_EN
    vert_t shd_q, shd_d;
    logic  pend_q, pend_d;

    always_comb begin
        shd_d  = shd_q;
        act_d  = act_q;
        pend_d = pend_q;
        if (wr_en) begin
            shd_d = write_vertex(shd_q, wr_addr, wr_data);
        end
        // The copy reads shd_q, so a write in the same cycle lands in the shadow only.
        if ((h_cnt_q == '0) && (v_cnt_q == V_VIS) && pend_q) begin
            act_d  = shd_q;
            pend_d = 1'b0;
        end
        if (wr_commit) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shd_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            shd_q  <= shd_d;
            pend_q <= pend_d;
        end
    end

    assign commit_pending = pend_q;
`else
    logic unused_commit;
    assign unused_commit = wr_commit;

    always_comb begin
        act_d = act_q;
        if (wr_en) begin
            act_d = write_vertex(act_q, wr_addr, wr_data);
        end
    end

    assign commit_pending = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
            act_q         <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            act_q         <= act_d;
        end
    end

    assign rgb         = rgb_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
    assign v0_x        = act_q.v0_x;
    assign v0_y        = act_q.v0_y;
    assign v1_x        = act_q.v1_x;
    assign v1_y        = act_q.v1_y;
    assign v2_x        = act_q.v2_x;
    assign v2_y        = act_q.v2_y;

endmodule

// File: tb/tb_raster_scan_driver.sv
// Randomized bench for raster_scan_driver on a reduced raster (same porch/sync widths),
// checked every cycle against a position-from-clock-count reference model.
module tb_raster_scan_driver;
    localparam int HV    = 64;
    localparam int VV    = 16;
    localparam int HT    = HV + 16 + 96 + 48;
    localparam int VT    = VV + 10 + 2 + 33;
    localparam int FRAME = HT * VT;
    localparam int RST_C = 2 * FRAME + 8 * HT;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [9:0] wr_data;
    logic       wr_commit;
    logic       commit_pending;
    logic [5:0] fg_color;
    logic [5:0] bg_color;
    logic [9:0] pixel_col;
    logic [8:0] pixel_row;
    logic [9:0] v0_x, v1_x, v2_x;
    logic [8:0] v0_y, v1_y, v2_y;
    logic       rasterize;
    logic       hsync;
    logic       vsync;
    logic [5:0] rgb;
    logic       frame_start;
    logic [9:0] thr;

    raster_scan_driver #(
        .H_VISIBLE(HV), .V_VISIBLE(VV), .H_TOTAL(HT), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_commit(wr_commit), .commit_pending(commit_pending),
        .fg_color(fg_color), .bg_color(bg_color),
        .pixel_col(pixel_col), .pixel_row(pixel_row),
        .v0_x(v0_x), .v1_x(v1_x), .v2_x(v2_x), .v0_y(v0_y), .v1_y(v1_y), .v2_y(v2_y),
        .rasterize(rasterize), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .frame_start(frame_start)
    );

    // Stand-in rasterizer: inside when the column is left of a threshold.
    assign rasterize = (pixel_col < thr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (time %0t)", tag, got, exp, $time);
    endtask

    // Reference model state: t = clocks since reset release, expected register contents.
    int       t;
    int       act[6];
    int       shd[6];
    bit       pend;
    bit [5:0] e_rgb;
    bit       e_hs, e_vs, e_fs;
    bit       seg0;
    int       hs_cnt, hs_first, vs_cnt, fs_cnt;

    function automatic int wmask(int a, int d);
        return (a % 2 == 1) ? (d & 'h1FF) : (d & 'h3FF);
    endfunction

    task automatic step();
        int h, v, col, ht, vt, a;
        if (!rst_n) begin
            t = 0; e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; pend = 1'b0;
            for (int i = 0; i < 6; i++) begin act[i] = 0; shd[i] = 0; end
        end else begin
            h   = t % HT;
            v   = (t / HT) % VT;
            col = (h < HV) ? h : 0;
            e_rgb = (h < HV && v < VV) ? ((col < int'(thr)) ? fg_color : bg_color) : 6'd0;
            e_hs  = !(h >= HV + 16 && h < HV + 112);
            e_vs  = !(v >= VV + 10 && v < VV + 12);
            e_fs  = (h == 0 && v == 0);
            a = int'(wr_addr);
`ifdef VERTEX_DOUBLE_BUFFER_EN
            if (h == 0 && v == VV && pend) begin
                for (int i = 0; i < 6; i++) act[i] = shd[i];
                pend = 1'b0;
            end
            if (wr_en && a < 6) shd[a] = wmask(a, int'(wr_data));
            if (wr_commit) pend = 1'b1;
`else
            if (wr_en && a < 6) act[a] = wmask(a, int'(wr_data));
`endif
            t++;
        end
        @(posedge clk);
        @(negedge clk);
        ht = t % HT;
        vt = (t / HT) % VT;
        check("pixel_col", 32'(pixel_col), (ht < HV) ? ht : 0);
        check("pixel_row", 32'(pixel_row), (vt < VV) ? vt : 0);
        check("rgb", 32'(rgb), 32'(e_rgb));
        check("hsync", 32'(hsync), 32'(e_hs));
        check("vsync", 32'(vsync), 32'(e_vs));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("commit_pending", 32'(commit_pending), 32'(pend));
        check("v0_x", 32'(v0_x), act[0]);
        check("v0_y", 32'(v0_y), act[1]);
        check("v1_x", 32'(v1_x), act[2]);
        check("v1_y", 32'(v1_y), act[3]);
        check("v2_x", 32'(v2_x), act[4]);
        check("v2_y", 32'(v2_y), act[5]);
        if (seg0 && rst_n) begin
            if (t >= 1 && t <= HT && hsync === 1'b0) begin
                hs_cnt++;
                if (hs_first == 0) hs_first = t;
            end
            if (t >= 1 && t <= FRAME && vsync === 1'b0) vs_cnt++;
            if (t >= 1 && t <= 2 * FRAME && frame_start === 1'b1) fs_cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_commit = 1'b0;
        fg_color = 6'h3F; bg_color = 6'h01; thr = 10'd20;
        seg0 = 1'b1; hs_cnt = 0; hs_first = 0; vs_cnt = 0; fs_cnt = 0;
        repeat (3) step();

        for (int c = 0; c < RST_C + FRAME + 200; c++) begin
            rst_n = 1'b1; wr_en = 1'b0; wr_commit = 1'b0;
            if (c >= FRAME) begin
                if ($urandom % 40 == 0) begin
                    wr_en = 1'b1; wr_addr = 3'($urandom); wr_data = 10'($urandom);
                end
                if ($urandom % 300 == 0) wr_commit = 1'b1;
                if ($urandom % 500 == 0) begin
                    fg_color = 6'($urandom); bg_color = 6'($urandom);
                    thr = 10'($urandom_range(0, HV + 6));
                end
            end
            if (c == 5 * HT + 10) begin wr_en = 1'b1; wr_addr = 3'd0; wr_data = 10'd320; end
            if (c == 5 * HT + 11) wr_commit = 1'b1;
            if (c == FRAME + VV * HT - 50) wr_commit = 1'b1;
            if (c == FRAME + VV * HT) begin
                wr_commit = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 10'($urandom);
            end
            if (c == RST_C - 3) wr_commit = 1'b1;
            if (c == RST_C) begin rst_n = 1'b0; seg0 = 1'b0; end
            step();
        end

        check("hsync_low_count", hs_cnt, 96);
        check("hsync_first_low", hs_first, HV + 17);
        check("vsync_low_count", vs_cnt, 2 * HT);
        check("frame_start_count", fs_cnt, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/raster_scan_driver.md
# raster_scan_driver

Pixel-scan front end that drives the triangle rasterizer. It generates 640x480@60 VGA timing from a 25.175 MHz pixel clock. It presents the current pixel coordinate and the active triangle vertices to the combinational rasterizer, then registers the returned inside/outside bit into RGB222 output aligned with the sync pulses. A host-side write port loads vertices, which are committed only during vertical blanking so a frame is never torn.

## Interface
Parameters:
- H_VISIBLE, 640, visible columns
- V_VISIBLE, 480, visible rows
- H_TOTAL, 800, pixel clocks per line (front porch 16, sync 96, back porch 48)
- V_TOTAL, 525, lines per frame (front porch 10, sync 2, back porch 33)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; synchronous, active-low
- wr_en  in  1  vertex write strobe
- wr_addr  in  3  0=v0_x 1=v0_y 2=v1_x 3=v1_y 4=v2_x 5=v2_y; 6,7 ignored
- wr_data  in  10  coordinate; y targets use [8:0]
- wr_commit  in  1  request commit of written vertices
- commit_pending  out  1  commit requested, not yet applied
- fg_color  in  6  RGB222 colour for inside pixels
- bg_color  in  6  RGB222 colour for outside visible pixels
- pixel_col  out  10  current column to rasterizer
- pixel_row  out  9  current row to rasterizer
- v0_x, v1_x, v2_x  out  10  active vertex x
- v0_y, v1_y, v2_y  out  9  active vertex y
- rasterize  in  1  rasterizer result for pixel_col/pixel_row (combinational, same cycle)
- hsync  out  1  active-low
- vsync  out  1  active-low
- rgb  out  6  pixel colour; 0 during blanking
- frame_start  out  1  one-cycle pulse at h=0, v=0

## Operation
- Counters:
  - h_cnt is 0..H_TOTAL-1. It wraps to 0 and increments v_cnt at h_cnt=H_TOTAL-1.
  - v_cnt is 10 bits, 0..V_TOTAL-1. It wraps to 0 at the end of the frame.
- display_on = h_cnt<640 && v_cnt<480.
- pixel_col = h_cnt when h_cnt<640, else 0.
- pixel_row = v_cnt[8:0] when v_cnt<480, else 0.
- hsync_raw is low for h_cnt in 656..751. vsync_raw is low for v_cnt in 490..491.
- Colour: the rgb register loads, on each clock:
  - fg_color if display_on && rasterize;
  - bg_color if display_on && !rasterize;
  - 0 otherwise.
- hsync and vsync are hsync_raw/vsync_raw delayed one register, so they stay aligned with rgb.
- Vertex writes: when wr_en=1, wr_data is written into the shadow register selected by wr_addr. Addresses 6 and 7 are no-ops.
- Commit:
  - wr_commit sets commit_pending.
  - At the cycle where h_cnt=0 and v_cnt=480 (blanking start), if commit_pending=1, all six shadow registers are copied to the active outputs and commit_pending clears.
  - A wr_en in the same cycle as the copy updates the shadow only; the copy uses the pre-write shadow value.
  - A wr_commit in the same cycle as the copy leaves commit_pending=1, so the data commits next frame.
- frame_start is registered and asserts together with the first visible pixel's rgb, i.e. one cycle after h_cnt=0, v_cnt=0.

## Timing
- Reset values:
  - h_cnt=0, v_cnt=0, so pixel_col=0 and pixel_row=0.
  - rgb=0, hsync=1, vsync=1, frame_start=0, commit_pending=0.
  - All shadow and active vertices = 0.
- Latency: one clock from pixel_col/pixel_row to the corresponding rgb. The rasterizer path must close combinationally within one pixel clock.
- Active vertices change only at h=0, v=480. They are constant across every visible pixel of a frame.
- Reset mid-frame: counters restart at (0,0) on the next edge and any pending commit is discarded.
- Line: 800 clocks. Frame: 420 000 clocks.

## Configuration
- VERTEX_DOUBLE_BUFFER_EN defined: shadow/commit behaviour exactly as in Operation.
- VERTEX_DOUBLE_BUFFER_EN undefined:
  - wr_en writes the active registers directly, effective the next cycle.
  - wr_commit is ignored and commit_pending is tied 0.
  - No shadow registers are built.

## Test plan
- Reset: release rst_n, count 800 clocks → hsync low exactly on clocks 657..752 after release (one-cycle delay), and pixel_col wraps 639→0 at h=640.
- Frame: run 420 000 clocks → vsync low for exactly 1600 clocks, and frame_start pulses once per 420 000 clocks.
- Colour: fg=6'h3F, bg=6'h01, rasterize tied to (pixel_col<100) → rgb=3F for the first 100 visible clocks of each line, then 01 for the rest of the visible line, and 0 in blanking.
- Commit: write v0_x=320 mid-frame, pulse wr_commit → v0_x output stays at its old value until h=0, v=480, then reads 320; commit_pending falls on the same edge.
- Collision: wr_commit asserted in the commit cycle → commit_pending remains 1 and commits at the next frame's v=480.
- Reset mid-frame: assert rst_n=0 at v=200 with a commit pending → all outputs return to reset values next clock and commit_pending=0 (with VERTEX_DOUBLE_BUFFER_EN undefined: a write is visible on the next cycle).
